rr_grant_arbiter: RTL
=====================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource between REQUESTERS requesters.
- Holds a registered one-hot grant until the owner releases it or a hold timeout expires.
- Produces the binary owner index through the team's existing encoder block.
- Sits in front of shared wire/bus resources so the datapath can use grant_index_o directly as a mux select.

Parameters:
- REQUESTERS, 4: number of requesters. Any value ≥ 1; non-power-of-2 values are legal.
- MAX_HOLD, 0: maximum cycles a grant may be held. 0 means unlimited; otherwise 1..2^16-1.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  REQUESTERS  request vector; bit k means requester k wants the resource.
- release_i  input  1  current owner finished; meaningful only while busy_o=1.
- grant_o  output  REQUESTERS  registered one-hot grant, or all-zero when idle.
- grant_index_o  output  $clog2(max(REQUESTERS,2))  binary index of the set grant_o bit; 0 when idle.
- busy_o  output  1  resource currently owned (equals |grant_o).
- timeout_o  output  1  one-cycle pulse on the edge where MAX_HOLD forces a release.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - grant_o=0, grant_index_o=0, busy_o=0, timeout_o=0.
  - Priority pointer=0, hold counter=0, state=IDLE.
- States: IDLE and OWNED.
- Selection rule:
  - Winner is the first set bit of req_i scanning upward from the pointer, wrapping from REQUESTERS-1 to 0.
  - Pointer range is 0..REQUESTERS-1; the wrap is exact for non-power-of-2 REQUESTERS.
- IDLE:
  - If |req_i, the next edge sets grant_o to the winner, enters OWNED and clears the hold counter.
  - Latency from request to grant is 1 cycle.
  - release_i is ignored in IDLE.
- OWNED:
  - Grant is held regardless of req_i, including when the owner deasserts its request.
  - Hold counter increments every cycle, saturating.
- End of ownership: release_i=1, or (MAX_HOLD≠0 and counter==MAX_HOLD-1). On that edge:
  - Pointer becomes (owner+1) mod REQUESTERS.
  - Re-arbitration happens on the same edge using the new pointer and the current req_i. This gives zero-bubble back-to-back grants.
  - If no requests are pending, go to IDLE with grant_o=0.
  - The previous owner has lowest priority but is re-granted if it is the sole requester.
- timeout_o:
  - Asserted for exactly the cycle after a forced end, registered.
  - Not asserted when release_i and the timeout coincide; release takes precedence.
- MAX_HOLD=1: every grant lasts exactly 1 cycle.
- REQUESTERS=1:
  - Pointer is constant 0.
  - grant_index_o is 1 bit and always 0.
  - Grant is re-issued back-to-back while req_i=1.
- grant_index_o: derived combinationally from registered grant_o, so it is glitch-free relative to grant_o.
- busy_o: a registered copy of state==OWNED.
- Reset asserted mid-ownership:
  - Grant drops immediately and the pointer returns to 0.
  - After deassertion, arbitration restarts from requester 0.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum {ARB_IDLE, ARB_OWNED} arb_state_t.
  - Constant ARB_HOLD_WIDTH=16.
- Width helpers: the codebase's existing max/min macros.
- One sub-module, the existing encoder, instantiated with INPUT_WIDTH=REQUESTERS. It converts grant_o into grant_index_o.
- Rotating priority selection is done inline: double-width request vector, masked by pointer, first-one search.

Test Plan:
- Reset: hold rst_i=1 with req_i=4'b1111 → grant_o=0, busy_o=0. First edge after release → grant_o=4'b0001, grant_index_o=0.
- Rotation: REQUESTERS=4, req_i=4'b1111, pulse release_i every 3rd cycle → grants go 0001, 0010, 0100, 1000, 0001 with no idle cycle between them.
- Wrap with non-power-of-2: REQUESTERS=5, owner=4, req_i=5'b10001, release_i=1 → next grant_o=5'b00001, grant_index_o=0.
- Hold independence: owner 2 drops req_i while release_i=0 for 10 cycles → grant_o stays 4'b0100. release_i with req_i=0 → grant_o=0, busy_o=0 next cycle.
- Timeout: MAX_HOLD=4, req_i=4'b0011 with no release → owner 0 held 4 cycles, then grant_o=4'b0010 and timeout_o pulses 1 cycle. A release_i on cycle 4 suppresses timeout_o.
- Asynchronous reset mid-grant: rst_i asserted between edges while grant_o=4'b1000 → outputs go 0 before the next edge; pointer returns to 0, so the next grant is requester 0.

Source files
------------

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types, constants and width macros for the round-robin grant arbiter.
`ifndef ARB_MAX
`define ARB_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif
`ifndef ARB_MIN
`define ARB_MIN(a, b) (((a) < (b)) ? (a) : (b))
`endif

package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_t;

  localparam int ARB_HOLD_WIDTH = 16;

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if #(
  parameter int REQUESTERS = 4
);

  localparam int IDX_W = $clog2(`ARB_MAX(REQUESTERS, 2));

  logic [REQUESTERS-1:0] req_i;
  logic                  release_i;
  logic [REQUESTERS-1:0] grant_o;
  logic [IDX_W-1:0]      grant_index_o;
  logic                  busy_o;
  logic                  timeout_o;

  modport master (
    output req_i,
    output release_i,
    input  grant_o,
    input  grant_index_o,
    input  busy_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  release_i,
    output grant_o,
    output grant_index_o,
    output busy_o,
    output timeout_o
  );

endinterface

// File: rtl/rr_grant_arbiter_enc.sv
// One-hot to binary encoder; a zero input encodes to index 0.
module rr_grant_arbiter_enc #(
  parameter int INPUT_WIDTH = 4
) (
  input  logic [INPUT_WIDTH-1:0]                        onehot_i,
  output logic [$clog2(`ARB_MAX(INPUT_WIDTH, 2))-1:0]   index_o
);

  localparam int OUTPUT_WIDTH = $clog2(`ARB_MAX(INPUT_WIDTH, 2));

  // OR of the indices of all set bits, exact for a one-hot input.
  always_comb begin
    index_o = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (onehot_i[i]) begin
        index_o = index_o | OUTPUT_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held until release or hold timeout.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int MAX_HOLD   = 0
) (
  input logic               clk_i,
  input logic               rst_i,
  rr_grant_arbiter_if.slave bus
);

  localparam int IDX_W  = $clog2(`ARB_MAX(REQUESTERS, 2));
  localparam int HOLD_W = ARB_HOLD_WIDTH;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_t              state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0]       holdCnt_q, holdCnt_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;

  logic [IDX_W-1:0]        ownerIdx;
  logic [IDX_W-1:0]        ownerNext;
  logic [IDX_W-1:0]        arbPtr;
  logic                    timeoutHit;
  logic                    endOwn;
  logic [2*REQUESTERS-1:0] reqDouble;
  logic [REQUESTERS-1:0]   winGrant;
  logic                    found;

  rr_grant_arbiter_enc #(
    .INPUT_WIDTH(REQUESTERS)
  ) u_enc (
    .onehot_i (grant_q),
    .index_o  (ownerIdx)
  );

  assign ownerNext  = (int'(ownerIdx) == REQUESTERS - 1) ? '0 : ownerIdx + IDX_W'(1);
  assign timeoutHit = (MAX_HOLD != 0) && (holdCnt_q == HOLD_LAST);
  assign endOwn     = (state_q == ARB_OWNED) && (bus.release_i || timeoutHit);

  // While owned, the next arbitration already uses the rotated pointer so
  // a back-to-back grant lands on the same edge as the release.
  assign arbPtr = (state_q == ARB_OWNED) ? ownerNext : ptr_q;

  always_comb begin
    reqDouble = {bus.req_i, bus.req_i};
    winGrant  = '0;
    found     = 1'b0;
    for (int i = 0; i < 2 * REQUESTERS; i++) begin
      if (!found && reqDouble[i] && (i >= int'(arbPtr))) begin
        found    = 1'b1;
        winGrant = REQUESTERS'(1) << ((i >= REQUESTERS) ? (i - REQUESTERS) : i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    holdCnt_d = holdCnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.req_i) begin
          state_d   = ARB_OWNED;
          grant_d   = winGrant;
          holdCnt_d = '0;
        end
      end
      ARB_OWNED: begin
        if (endOwn) begin
          ptr_d     = ownerNext;
          timeout_d = !bus.release_i;
          holdCnt_d = '0;
          if (|bus.req_i) begin
            grant_d = winGrant;
          end else begin
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end else if (holdCnt_q != '1) begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d == ARB_OWNED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.grant_o       = grant_q;
  assign bus.grant_index_o = ownerIdx;
  assign bus.busy_o        = busy_q;
  assign bus.timeout_o     = timeout_q;

endmodule
